// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/done controller driving a ripple chain of NUM_DIGITS digit counters.
// Optional lap/freeze feature compiled in with `define STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  dir_up,
    input  logic [NUM_DIGITS-1:0] thr,
`ifdef STOPWATCH_CTRL_LAP_EN
    input  logic                  lap,
    output logic                  freeze,
`endif
    output logic [NUM_DIGITS-1:0] cnt_en,
    output logic                  cnt_up_down,
    output logic                  cnt_clr,
    output logic                  running,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r;
    logic                  ss_prev_r;
    logic                  clr_prev_r;
    logic                  armed_r;
    logic                  cnt_up_down_r;
    logic                  cnt_clr_r;
    logic                  ss_edge_s;
    logic                  clr_edge_s;
    logic                  zero_hit_s;
    logic [NUM_DIGITS-1:0] en_s;

    // armed_r masks the first cycle after reset so a level already high is not taken as an edge
    assign ss_edge_s  = armed_r & start_stop & ~ss_prev_r;
    assign clr_edge_s = armed_r & clear & ~clr_prev_r;
    assign zero_hit_s = (state_r == ST_RUN) & tick & ~cnt_up_down_r & (&thr);

    // Ripple enable chain; the whole chain is suppressed when a down count reaches zero
    always_comb begin
        en_s = '0;
        if ((state_r == ST_RUN) && !zero_hit_s) begin
            en_s[0] = tick;
        end else begin
            en_s[0] = 1'b0;
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            en_s[i] = en_s[i-1] & thr[i-1];
        end
    end

    // Control FSM with edge-detect history, direction latch and clear pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ss_prev_r     <= 1'b0;
            clr_prev_r    <= 1'b0;
            armed_r       <= 1'b0;
            cnt_up_down_r <= 1'b1;
            cnt_clr_r     <= 1'b0;
        end else begin
            ss_prev_r  <= start_stop;
            clr_prev_r <= clear;
            armed_r    <= 1'b1;
            cnt_clr_r  <= clr_edge_s;
            if (state_r == ST_IDLE) begin
                cnt_up_down_r <= dir_up;
            end else begin
                cnt_up_down_r <= cnt_up_down_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (clr_edge_s) begin
                        state_r <= ST_IDLE;
                    end else if (ss_edge_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (clr_edge_s) begin
                        state_r <= ST_IDLE;
                    end else if (zero_hit_s) begin
                        state_r <= ST_DONE;
                    end else if (ss_edge_s) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (clr_edge_s) begin
                        state_r <= ST_IDLE;
                    end else if (ss_edge_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (clr_edge_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_prev_r;
    logic freeze_r;
    logic lap_edge_s;

    assign lap_edge_s = armed_r & lap & ~lap_prev_r;

    // Lap freeze toggles only while running and drops whenever the FSM heads to IDLE or DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_prev_r <= 1'b0;
            freeze_r   <= 1'b0;
        end else begin
            lap_prev_r <= lap;
            if (clr_edge_s || zero_hit_s) begin
                freeze_r <= 1'b0;
            end else if (lap_edge_s && (state_r == ST_RUN)) begin
                freeze_r <= ~freeze_r;
            end else begin
                freeze_r <= freeze_r;
            end
        end
    end

    assign freeze = freeze_r;
`endif

    assign cnt_en      = en_s;
    assign cnt_up_down = cnt_up_down_r;
    assign cnt_clr     = cnt_clr_r;
    assign running     = (state_r == ST_RUN);
    assign done        = (state_r == ST_DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl; lap checks compile in with STOPWATCH_CTRL_LAP_EN.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic       dir_up;
    logic [3:0] thr;
    logic [3:0] cnt_en;
    logic       cnt_up_down;
    logic       cnt_clr;
    logic       running;
    logic       done;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic       lap_s;
    logic       freeze;
`endif

    int tests_run = 0;
    int fails     = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    stopwatch_ctrl #(.NUM_DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .start_stop  (start_stop),
        .clear       (clear),
        .dir_up      (dir_up),
        .thr         (thr),
`ifdef STOPWATCH_CTRL_LAP_EN
        .lap         (lap_s),
        .freeze      (freeze),
`endif
        .cnt_en      (cnt_en),
        .cnt_up_down (cnt_up_down),
        .cnt_clr     (cnt_clr),
        .running     (running),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] mk(input logic f, input logic r, input logic d,
                                      input logic c, input logic u, input logic [3:0] en);
        return {f, r, d, c, u, en};
    endfunction

    function automatic logic [8:0] observe();
        logic f;
`ifdef STOPWATCH_CTRL_LAP_EN
        f = freeze;
`else
        f = 1'b0;
`endif
        return {f, running, done, cnt_clr, cnt_up_down, cnt_en};
    endfunction

    task automatic compare_front();
        logic [8:0] e;
        logic [8:0] o;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observe();
        tests_run++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed={frz,run,done,clr,ud,en}=%b expected=%b", t, o, e);
        end
    endtask

    // Drive inputs at the current time (just after a falling edge) and check outputs 2 time units later
    task automatic drive_check(input string tag, input logic t, input logic ss, input logic cl,
                               input logic dir, input logic [3:0] th, input logic [8:0] e);
        tick = t; start_stop = ss; clear = cl; dir_up = dir; thr = th;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        compare_front();
    endtask

    task automatic step(input string tag, input logic t, input logic ss, input logic cl,
                        input logic dir, input logic [3:0] th, input logic [8:0] e);
        @(negedge clk);
        drive_check(tag, t, ss, cl, dir, th, e);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start_stop = 1'b1; clear = 1'b0; dir_up = 1'b1; thr = 4'b0000;
`ifdef STOPWATCH_CTRL_LAP_EN
        lap_s = 1'b0;
`endif
        repeat (2) @(negedge clk);
        step("reset_state",     1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        @(negedge clk) rst_n = 1'b1;
        step("held_high_no_edge", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("idle_quiet",      1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("start_edge_idle", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("run_ripple_0111", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111));
        step("run_no_tick",     1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("up_wrap_all_max", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111));
        step("up_after_wrap",   1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001));
        // simultaneous start_stop and clear edges resolve as clear only
        step("both_edges_run",  1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("clr_pulse_idle",  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000));
        step("clr_pulse_1cyc",  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        // direction latch holds outside IDLE
        step("restart",         1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("run_again",       1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("pause_edge",      1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("pause_dir_hold",  1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("pause_clear",     1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("idle_clr_ud_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000));
        step("idle_dir_loaded", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
        // down count reaching zero
        step("down_start",      1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
        step("down_ripple",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011));
        step("down_zero_hold",  1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
        step("done_state",      1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000));
        step("done_ignore_ss",  1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000));
        step("done_clear_edge", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000));
        step("done_to_idle",    1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000));
        step("idle_reload_up",  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("idle_clear_edge", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("idle_clr_pulse",  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000));
        // asynchronous reset in the middle of a down run
        step("pre_rst_start",   1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step("pre_rst_run",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011));
        @(negedge clk);
        tick = 1'b1; start_stop = 1'b0; clear = 1'b0; dir_up = 1'b0; thr = 4'b0001;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        tag_q.push_back("async_reset_midrun");
        #1 rst_n = 1'b0;
        #1 compare_front();
        @(negedge clk) rst_n = 1'b1;
`ifdef STOPWATCH_CTRL_LAP_EN
        step("lap_idle",        1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        @(negedge clk); lap_s = 1'b1;
        drive_check("lap_edge1",   1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111));
        @(negedge clk); lap_s = 1'b0;
        drive_check("lap_frz_on",  1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111));
        @(negedge clk); lap_s = 1'b1;
        drive_check("lap_edge2",   1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111));
        @(negedge clk); lap_s = 1'b0;
        drive_check("lap_frz_off", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111));
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
